// File: rtl/cpu_controller.sv
// Instruction register and multi-cycle control FSM for a 16-bit datapath.
// Outputs are Moore-style: they depend only on the current state and the held instruction.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic        write
);

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWriteImm,
    StGetA,
    StGetB,
    StAlu,
    StWriteReg,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp, is_halt;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_halt    = (opcode == 3'b111);

  assign shift  = ir_q[4:3];
  assign ALUop  = op;
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Capturing only in WAIT means a load alongside s is what DECODE sees next cycle.
  always_comb begin
    ir_d = ir_q;
    if ((state_q == StWait) && load) begin
      ir_d = in;
    end
  end

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    unique case (state_q)
      StWait: begin
        w = 1'b1;
        if (s) state_d = StDecode;
      end
      StDecode: begin
        if (is_mov_imm)                state_d = StWriteImm;
        else if (is_mov_reg || is_mvn) state_d = StGetB;
        else if (is_alu)               state_d = StGetA;
        else if (is_halt)              state_d = StHalt;
        else                           state_d = StWait;
      end
      StWriteImm: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
        state_d  = StWait;
      end
      StGetA: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = StGetB;
      end
      StGetB: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = StAlu;
      end
      StAlu: begin
        loadc   = 1'b1;
        asel    = is_mov_reg || is_mvn;
        loads   = is_cmp;
        state_d = is_cmp ? StWait : StWriteReg;
      end
      StWriteReg: begin
        writenum = rd;
        vsel     = 2'b00;
        write    = 1'b1;
        state_d  = StWait;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StWait;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: a per-instruction vector table plus hand-written
// sequences for per-state outputs, mid-run load, reset abort and HALT.
module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic        s;
  logic        load;
  logic [15:0] in_w;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, alu_op;
  logic [15:0] sximm5, sximm8;
  logic [1:0]  vsel;
  logic        loada, loadb, asel, bsel, loadc, loads, write;

  int checks;
  int errors;

  cpu_controller dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .load     (load),
    .in       (in_w),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .shift    (shift),
    .ALUop    (alu_op),
    .sximm5   (sximm5),
    .sximm8   (sximm8),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .asel     (asel),
    .bsel     (bsel),
    .loadc    (loadc),
    .loads    (loads),
    .write    (write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          lat;
    int          n_write;
    int          n_loada;
    int          n_loadb;
    int          n_loadc;
    int          n_loads;
    logic [2:0]  wnum;
    logic [1:0]  wvsel;
    logic        alu_asel;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s     = 1'b0;
    load  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic load_and_start(input logic [15:0] instr);
    in_w = instr;
    load = 1'b1;
    s    = 1'b1;
    step();
    load = 1'b0;
    s    = 1'b0;
  endtask

  initial begin
    int nw, nla, nlb, nlc, nls, lat, n;
    logic [2:0] gw;
    logic [1:0] gv;
    logic       ga, gb;

    checks = 0;
    errors = 0;
    reset  = 1'b0;
    s      = 1'b0;
    load   = 1'b0;
    in_w   = 16'h0000;

    //            instr     lat wr la lb lc ls wnum  vsel   asel
    vec[0] = '{16'hD007, 2, 1, 0, 0, 0, 0, 3'd0, 2'b10, 1'b0}; // MOV R0,#7
    vec[1] = '{16'hD1FE, 2, 1, 0, 0, 0, 0, 3'd1, 2'b10, 1'b0}; // MOV R1,#-2
    vec[2] = '{16'hA148, 5, 1, 1, 1, 1, 0, 3'd2, 2'b00, 1'b0}; // ADD R2,R1,R0,LSL#1
    vec[3] = '{16'hA801, 4, 0, 1, 1, 1, 1, 3'd0, 2'b00, 1'b0}; // CMP R0,R1
    vec[4] = '{16'hB385, 5, 1, 1, 1, 1, 0, 3'd4, 2'b00, 1'b0}; // AND R4,R3,R5
    vec[5] = '{16'hB8E2, 4, 1, 0, 1, 1, 0, 3'd7, 2'b00, 1'b1}; // MVN R7,R2
    vec[6] = '{16'hC071, 4, 1, 0, 1, 1, 0, 3'd3, 2'b00, 1'b1}; // MOV R3,R1,LSR
    vec[7] = '{16'hC800, 1, 0, 0, 0, 0, 0, 3'd0, 2'b00, 1'b0}; // unsupported 110/01
    vec[8] = '{16'h0000, 1, 0, 0, 0, 0, 0, 3'd0, 2'b00, 1'b0}; // unsupported opcode 000

    // Reset state
    do_reset();
    chk("reset_flags", {24'd0, w, loada, loadb, loadc, loads, write, asel, bsel}, 32'h80);
    chk("reset_ir", {16'd0, sximm8}, 32'h0);

    // Table: load and s together, so the freshly loaded word must be the one executed
    for (int i = 0; i < NV; i++) begin
      do_reset();
      load_and_start(vec[i].instr);
      nw = 0; nla = 0; nlb = 0; nlc = 0; nls = 0; lat = -1;
      gw = 3'd0; gv = 2'b00; ga = 1'b0; gb = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        step();
        nw  += int'(write);
        nla += int'(loada);
        nlb += int'(loadb);
        nlc += int'(loadc);
        nls += int'(loads);
        if (write) begin
          gw = writenum;
          gv = vsel;
        end
        if (loadc) begin
          ga = asel;
          gb = bsel;
        end
        if (w) begin
          lat = c;
          break;
        end
      end
      chk($sformatf("v%0d_latency", i), lat, vec[i].lat);
      chk($sformatf("v%0d_writes", i), nw, vec[i].n_write);
      chk($sformatf("v%0d_loada", i), nla, vec[i].n_loada);
      chk($sformatf("v%0d_loadb", i), nlb, vec[i].n_loadb);
      chk($sformatf("v%0d_loadc", i), nlc, vec[i].n_loadc);
      chk($sformatf("v%0d_loads", i), nls, vec[i].n_loads);
      if (vec[i].n_write > 0) begin
        chk($sformatf("v%0d_writenum", i), gw, vec[i].wnum);
        chk($sformatf("v%0d_vsel", i), gv, vec[i].wvsel);
      end
      if (vec[i].n_loadc > 0) begin
        chk($sformatf("v%0d_asel", i), ga, vec[i].alu_asel);
        chk($sformatf("v%0d_bsel", i), gb, 1'b0);
      end
    end

    // MOV imm, state by state
    do_reset();
    load_and_start(16'hD007);
    chk("movi_decode", {w, write}, 2'b00);
    step();
    chk("movi_write", {write, writenum, vsel}, {1'b1, 3'd0, 2'b10});
    chk("movi_sximm8", sximm8, 16'h0007);
    step();
    chk("movi_done", {w, write}, 2'b10);

    // Negative immediates sign-extend
    load_and_start(16'hD1FE);
    chk("neg_sximm8", sximm8, 16'hFFFE);
    chk("neg_sximm5", sximm5, 16'hFFFE);

    // ADD, state by state
    do_reset();
    load_and_start(16'hA148);
    step();
    chk("add_geta", {readnum, loada, loadb}, {3'd1, 1'b1, 1'b0});
    step();
    chk("add_getb", {readnum, loada, loadb, shift}, {3'd0, 1'b0, 1'b1, 2'b01});
    chk("add_sximm5", sximm5, 16'h0008);
    step();
    chk("add_alu", {alu_op, asel, bsel, loadc, loads}, {2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
    step();
    chk("add_wreg", {writenum, vsel, write}, {3'd2, 2'b00, 1'b1});

    // CMP ALU state
    do_reset();
    load_and_start(16'hA801);
    step();
    step();
    step();
    chk("cmp_alu", {alu_op, loadc, loads, write}, {2'b01, 1'b1, 1'b1, 1'b0});

    // Load asserted during a run must not touch IR
    do_reset();
    load_and_start(16'hA148);
    load = 1'b1;
    in_w = 16'hFFFF;
    for (int c = 0; c < 5; c++) step();
    load = 1'b0;
    chk("midload_w", w, 1'b1);
    chk("midload_ir", {sximm8, shift}, {16'h0048, 2'b01});

    // Reset during GET_B aborts the instruction
    do_reset();
    load_and_start(16'hA148);
    load = 1'b1;
    in_w = 16'hFFFF;
    step();
    step();
    chk("abort_in_getb", loadb, 1'b1);
    reset = 1'b1;
    step();
    chk("abort_wait", {w, write}, 2'b10);
    reset = 1'b0;
    load  = 1'b0;
    nw = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      nw += int'(write);
    end
    chk("abort_no_write", nw, 0);
    chk("abort_ir", {16'd0, sximm8}, 32'h0);

    // HALT ignores s and load until reset
    do_reset();
    load_and_start(16'hE000);
    step();
    chk("halt_w", w, 1'b0);
    s    = 1'b1;
    load = 1'b1;
    in_w = 16'hD007;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (w || write || loada || loadb || loadc || loads) n++;
    end
    chk("halt_stuck", n, 0);
    chk("halt_ir_kept", {16'd0, sximm8}, 32'h0);
    s    = 1'b0;
    load = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("halt_reset_w", w, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
